// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI command/register controller: register map,
// CTRL bit positions, FSM encoding and the error fill byte.
package spi_reg_pkg;

  typedef logic [6:0] addr_t;

  localparam addr_t ADDR_CTRL     = 7'd0;
  localparam addr_t ADDR_LOAD_VAL = 7'd1;
  localparam addr_t ADDR_COUNT    = 7'd2;
  localparam addr_t ADDR_LED      = 7'd3;
  localparam addr_t ADDR_ID       = 7'd4;
  localparam addr_t ADDR_MAX      = ADDR_ID;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_DIR  = 1;
  localparam int CTRL_CLR  = 2;
  localparam int CTRL_LOAD = 3;

  localparam logic [7:0] ERR_FILL = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR,
    ST_RD,
    ST_ERR
  } state_t;

  // Burst pointer steps through the valid map and wraps back to CTRL.
  function automatic addr_t next_addr(input addr_t a);
    return (a >= ADDR_MAX) ? ADDR_CTRL : addr_t'(a + 7'd1);
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI slave shifter (master side) and the
// register controller (slave side).
interface spi_reg_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              cs_active;
   logic              rx_valid;
   logic [DATA_W-1:0] rx_byte;
   logic [DATA_W-1:0] tx_byte;
   logic              tx_load;

   modport master (
      output cs_active, rx_valid, rx_byte,
      input  tx_byte, tx_load
   );

   modport slave (
      input  cs_active, rx_valid, rx_byte,
      output tx_byte, tx_load
   );
endinterface

// File: rtl/spi_reg_file.sv
// Register storage behind the SPI controller: CTRL/LOAD_VAL/LED registers,
// one-cycle clr/load pulses and the combinational read mux.
module spi_reg_file
   import spi_reg_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter int                N_LED  = 5,
   parameter logic [DATA_W-1:0] ID_VAL = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  addr_t             wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  addr_t             rd_addr,
   input  logic [DATA_W-1:0] cnt_value,
   output logic [DATA_W-1:0] rd_data,
   output logic              cnt_en,
   output logic              cnt_dir,
   output logic              cnt_clr,
   output logic              cnt_load,
   output logic [DATA_W-1:0] cnt_load_val,
   output logic [N_LED-1:0]  led
);

   logic wr_ctrl;
   assign wr_ctrl = wr_en && (wr_addr == ADDR_CTRL);

   // NOTE: every register here is a handful of flops driving pins, so all of
   // them take the async reset; there is no RAM-style storage to exclude.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_en       <= 1'b0;
         cnt_dir      <= 1'b0;
         cnt_clr      <= 1'b0;
         cnt_load     <= 1'b0;
         cnt_load_val <= '0;
         led          <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge
         // values, so statement order inside this block never matters.
         cnt_clr  <= wr_ctrl && wr_data[CTRL_CLR];
         cnt_load <= wr_ctrl && wr_data[CTRL_LOAD];
         if (wr_ctrl) begin
            cnt_en  <= wr_data[CTRL_EN];
            cnt_dir <= wr_data[CTRL_DIR];
         end
         if (wr_en && (wr_addr == ADDR_LOAD_VAL)) cnt_load_val <= wr_data;
         if (wr_en && (wr_addr == ADDR_LED))      led          <= wr_data[N_LED-1:0];
      end
   end

   // Pulse bits of CTRL read back as 0; COUNT is the live counter value.
   always_comb begin
      // NOTE: default first so no path through the case leaves rd_data
      // unassigned, which would otherwise infer a latch.
      rd_data = '0;
      case (rd_addr)
         ADDR_CTRL: begin
            rd_data[CTRL_EN]  = cnt_en;
            rd_data[CTRL_DIR] = cnt_dir;
         end
         ADDR_LOAD_VAL: rd_data = cnt_load_val;
         ADDR_COUNT:    rd_data = cnt_value;
         ADDR_LED:      rd_data[N_LED-1:0] = led;
         ADDR_ID:       rd_data = ID_VAL;
         default:       rd_data = '0;
      endcase
   end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller: decodes one command byte per CE0 frame,
// then performs burst register writes or streams register reads.
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter int                N_LED  = 5,
   parameter logic [DATA_W-1:0] ID_VAL = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_reg_ctrl_if.slave     spi,
   input  logic [DATA_W-1:0] cnt_value,
   output logic              cnt_en,
   output logic              cnt_dir,
   output logic              cnt_clr,
   output logic              cnt_load,
   output logic [DATA_W-1:0] cnt_load_val,
   output logic [N_LED-1:0]  led
);

   state_t            state;
   addr_t             ptr;
   addr_t             cmd_addr;
   logic              cmd_rd;
   addr_t             rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;

   assign cmd_addr = spi.rx_byte[6:0];
   assign cmd_rd   = spi.rx_byte[DATA_W-1];
   // The command byte itself selects the first read address.
   assign rd_addr  = (state == ST_CMD) ? cmd_addr : ptr;
   assign wr_en    = (state == ST_WR) && spi.rx_valid;

   spi_reg_file #(
      .DATA_W (DATA_W),
      .N_LED  (N_LED),
      .ID_VAL (ID_VAL)
   ) u_reg_file (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_addr      (ptr),
      .wr_data      (spi.rx_byte),
      .rd_addr      (rd_addr),
      .cnt_value    (cnt_value),
      .rd_data      (rd_data),
      .cnt_en       (cnt_en),
      .cnt_dir      (cnt_dir),
      .cnt_clr      (cnt_clr),
      .cnt_load     (cnt_load),
      .cnt_load_val (cnt_load_val),
      .led          (led)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         spi.tx_byte <= '0;
         spi.tx_load <= 1'b0;
      end else begin
         spi.tx_load <= 1'b0;
         case (state)
            ST_IDLE: if (spi.cs_active) state <= ST_CMD;
            ST_CMD: begin
               if (spi.rx_valid) begin
                  if (cmd_addr > ADDR_MAX) begin
                     state <= ST_ERR;
                  end else if (cmd_rd) begin
                     state       <= ST_RD;
                     spi.tx_byte <= rd_data;
                     spi.tx_load <= 1'b1;
                     ptr         <= next_addr(cmd_addr);
                  end else begin
                     state <= ST_WR;
                     ptr   <= cmd_addr;
                  end
               end
            end
            ST_WR: if (spi.rx_valid) ptr <= next_addr(ptr);
            ST_RD: begin
               if (spi.rx_valid) begin
                  spi.tx_byte <= rd_data;
                  spi.tx_load <= 1'b1;
                  ptr         <= next_addr(ptr);
               end
            end
            ST_ERR: begin
               if (spi.rx_valid) begin
                  spi.tx_byte <= DATA_W'(ERR_FILL);
                  spi.tx_load <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
         // Frame end wins over the transition above, but a byte arriving in
         // the same cycle has already been handled.
         if ((state != ST_IDLE) && !spi.cs_active) begin
            state <= ST_IDLE;
            ptr   <= '0;
         end
      end
   end

endmodule
